// File: rtl/ifmap_dbuf_if.sv
// Bus bundle between the ifmap beat source / PE array (master) and the
// double-buffered ifmap input controller (slave).
interface ifmap_dbuf_if #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned IC0             = 2,
    parameter int unsigned BANK_ADDR_WIDTH = 8,
    parameter int unsigned CONFIG_WIDTH    = 32,
    parameter int unsigned COUNTER_WID     = 8
);
    logic                          config_en;
    logic [CONFIG_WIDTH-1:0]       config_data;
    logic [DATA_WIDTH-1:0]         input_dat;
    logic                          input_vld;
    logic                          input_rdy;
    logic                          ren;
    logic [BANK_ADDR_WIDTH-1:0]    raddr;
    logic [DATA_WIDTH*IC0-1:0]     rdata;
    logic                          ready_to_switch;
    logic                          write_bank_ready_to_switch;
    logic [COUNTER_WID-1:0]        write_bank_count;
    logic                          bank_sel;

    modport master (
        output config_en, config_data, input_dat, input_vld, ren, raddr, ready_to_switch,
        input  input_rdy, rdata, write_bank_ready_to_switch, write_bank_count, bank_sel
    );

    modport slave (
        input  config_en, config_data, input_dat, input_vld, ren, raddr, ready_to_switch,
        output input_rdy, rdata, write_bank_ready_to_switch, write_bank_count, bank_sel
    );
endinterface

// File: rtl/ifmap_dbuf_input_controller.sv
// Chains IC0 input beats into wide words, fills a ping-pong double buffer and
// serves 1-cycle reads from the idle bank. Optional IFMAP_STALL_CNT_EN adds stall_count.
module ifmap_dbuf_input_controller #(
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned IC0              = 2,
    parameter int unsigned BUFFER_MEM_DEPTH = 256,
    parameter int unsigned BANK_ADDR_WIDTH  = 8,
    parameter int unsigned CONFIG_WIDTH     = 32,
    parameter int unsigned COUNTER_WID      = 8,
    parameter int unsigned OY1_OX1          = 2
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef IFMAP_STALL_CNT_EN
    output logic [COUNTER_WID-1:0] stall_count,
`endif
    ifmap_dbuf_if.slave            bus
);
    localparam int unsigned WORD_WIDTH = DATA_WIDTH * IC0;
    localparam int unsigned LANE_WIDTH = (IC0 > 1) ? $clog2(IC0) : 1;
    localparam int unsigned LEN_WIDTH  = BANK_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t                      state;
    logic                        input_rdy;
    logic                        full_flag;
    logic                        bank_sel;
    logic [COUNTER_WID-1:0]      bank_count;
    logic [WORD_WIDTH-1:0]       rdata;
    logic [LANE_WIDTH-1:0]       lane;
    logic [BANK_ADDR_WIDTH-1:0]  waddr;
    logic [LEN_WIDTH-1:0]        bank_len;

    logic [DATA_WIDTH-1:0]       lane_buf [IC0];
    logic [WORD_WIDTH-1:0]       mem [2][BUFFER_MEM_DEPTH];

    logic                        accept_c;
    logic                        last_lane_c;
    logic                        wr_en_c;
    logic                        bank_done_c;
    logic [WORD_WIDTH-1:0]       wdata_c;
    logic [LEN_WIDTH-1:0]        cfg_raw_c;
    logic [LEN_WIDTH-1:0]        cfg_len_c;
    logic                        unused_cfg;

    // input_rdy is only ever high in FILL, so it doubles as the state qualifier
    assign accept_c    = bus.input_vld & input_rdy;
    assign last_lane_c = (lane == LANE_WIDTH'(IC0 - 1));
    assign wr_en_c     = accept_c & last_lane_c & ~rst;
    assign bank_done_c = ({1'b0, waddr} == (bank_len - LEN_WIDTH'(1)));

    // Bank length: zero or oversize requests fall back to the full bank
    assign cfg_raw_c  = bus.config_data[LEN_WIDTH-1:0];
    assign cfg_len_c  = ((cfg_raw_c == '0) || (cfg_raw_c > LEN_WIDTH'(BUFFER_MEM_DEPTH)))
                        ? LEN_WIDTH'(BUFFER_MEM_DEPTH) : cfg_raw_c;
    assign unused_cfg = ^bus.config_data[CONFIG_WIDTH-1:LEN_WIDTH];

    // Final lane comes straight from the bus; earlier lanes from the chain buffer
    always_comb begin
        wdata_c = '0;
        for (int i = 0; i < int'(IC0) - 1; i++) begin
            wdata_c[i*DATA_WIDTH +: DATA_WIDTH] = lane_buf[i];
        end
        wdata_c[(IC0-1)*DATA_WIDTH +: DATA_WIDTH] = bus.input_dat;
    end

    // Control FSM with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bank_sel   <= 1'b0;
            input_rdy  <= 1'b0;
            full_flag  <= 1'b0;
            bank_count <= '0;
            lane       <= '0;
            waddr      <= '0;
            bank_len   <= LEN_WIDTH'(BUFFER_MEM_DEPTH);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.config_en) begin
                        bank_len  <= cfg_len_c;
                        state     <= FILL;
                        input_rdy <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept_c) begin
                        if (last_lane_c) begin
                            lane <= '0;
                            if (bank_done_c) begin
                                waddr      <= '0;
                                state      <= FULL;
                                input_rdy  <= 1'b0;
                                full_flag  <= 1'b1;
                                bank_count <= (bank_count == COUNTER_WID'(OY1_OX1 - 1))
                                              ? '0 : bank_count + COUNTER_WID'(1);
                            end else begin
                                waddr <= waddr + BANK_ADDR_WIDTH'(1);
                            end
                        end else begin
                            lane <= lane + LANE_WIDTH'(1);
                        end
                    end
                end
                FULL: begin
                    if (bus.ready_to_switch) begin
                        bank_sel  <= ~bank_sel;
                        state     <= FILL;
                        input_rdy <= 1'b1;
                        full_flag <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    input_rdy <= 1'b0;
                    full_flag <= 1'b0;
                end
            endcase
        end
    end

    // Partial-word chain storage
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lane_buf[lane] <= bus.input_dat;
        end
    end

    // Bank storage: write side uses bank_sel, contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[bank_sel][waddr] <= wdata_c;
        end
    end

    // Read port on the opposite bank; pre-switch bank_sel applies on a switch edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (bus.ren) begin
            rdata <= mem[~bank_sel][bus.raddr];
        end
    end

`ifdef IFMAP_STALL_CNT_EN
    // Saturating count of cycles a valid beat is held off by a full bank
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if ((state == FULL) && bus.input_vld && !input_rdy && (stall_count != '1)) begin
            stall_count <= stall_count + COUNTER_WID'(1);
        end
    end
`endif

    assign bus.input_rdy                  = input_rdy;
    assign bus.write_bank_ready_to_switch = full_flag;
    assign bus.write_bank_count           = bank_count;
    assign bus.bank_sel                   = bank_sel;
    assign bus.rdata                      = rdata;

endmodule

// File: tb/tb_ifmap_dbuf_input_controller.sv
// Directed bench for ifmap_dbuf_input_controller (IC0=2, 16-bit lanes, OY1_OX1=2).
module tb_ifmap_dbuf_input_controller;
    localparam int unsigned DW    = 16;
    localparam int unsigned IC0   = 2;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned BAW   = 8;
    localparam int unsigned CW    = 32;
    localparam int unsigned CNTW  = 8;
    localparam int unsigned OY    = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef IFMAP_STALL_CNT_EN
    logic [CNTW-1:0] stall_count;
`endif

    ifmap_dbuf_if #(
        .DATA_WIDTH(DW), .IC0(IC0), .BANK_ADDR_WIDTH(BAW),
        .CONFIG_WIDTH(CW), .COUNTER_WID(CNTW)
    ) bus ();

    ifmap_dbuf_input_controller #(
        .DATA_WIDTH(DW), .IC0(IC0), .BUFFER_MEM_DEPTH(DEPTH), .BANK_ADDR_WIDTH(BAW),
        .CONFIG_WIDTH(CW), .COUNTER_WID(CNTW), .OY1_OX1(OY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef IFMAP_STALL_CNT_EN
        .stall_count (stall_count),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.config_en       = 1'b0;
        bus.config_data     = '0;
        bus.input_dat       = '0;
        bus.input_vld       = 1'b0;
        bus.ren             = 1'b0;
        bus.raddr           = '0;
        bus.ready_to_switch = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        bus.input_vld = 1'b1;
        bus.input_dat = d;
        step();
    endtask

    task automatic do_config(input logic [CW-1:0] d);
        bus.config_en   = 1'b1;
        bus.config_data = d;
        step();
        bus.config_en   = 1'b0;
    endtask

    task automatic switch_bank();
        bus.ready_to_switch = 1'b1;
        step();
        bus.ready_to_switch = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        apply_reset();
        n_tests++; if (bus.input_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_input_rdy got=%0b exp=0", bus.input_rdy); end
        n_tests++; if (bus.write_bank_ready_to_switch !== 1'b0) begin n_fail++; $display("FAIL reset_wbrts got=%0b exp=0", bus.write_bank_ready_to_switch); end
        n_tests++; if (bus.write_bank_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.write_bank_count); end
        n_tests++; if (bus.bank_sel !== 1'b0) begin n_fail++; $display("FAIL reset_bank_sel got=%0b exp=0", bus.bank_sel); end
        n_tests++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
`ifdef IFMAP_STALL_CNT_EN
        n_tests++; if (stall_count !== 8'd0) begin n_fail++; $display("FAIL reset_stall got=%0d exp=0", stall_count); end
`endif
    endtask

    task automatic test_config();
        do_config(32'd8);
        n_tests++; if (bus.input_rdy !== 1'b1) begin n_fail++; $display("FAIL config_input_rdy got=%0b exp=1", bus.input_rdy); end
        n_tests++; if (bus.write_bank_count !== 8'd0) begin n_fail++; $display("FAIL config_count got=%0d exp=0", bus.write_bank_count); end
        n_tests++; if (bus.bank_sel !== 1'b0) begin n_fail++; $display("FAIL config_bank_sel got=%0b exp=0", bus.bank_sel); end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 16; k++) begin
            n_tests++; if (bus.input_rdy !== 1'b1) begin n_fail++; $display("FAIL fill_rdy_beat%0d got=%0b exp=1", k, bus.input_rdy); end
            send(16'(k));
        end
        // valid stays high with a new beat that must be held back
        bus.input_dat = 16'hAAAA;
        n_tests++; if (bus.input_rdy !== 1'b0) begin n_fail++; $display("FAIL fill_done_rdy got=%0b exp=0", bus.input_rdy); end
        n_tests++; if (bus.write_bank_ready_to_switch !== 1'b1) begin n_fail++; $display("FAIL fill_done_wbrts got=%0b exp=1", bus.write_bank_ready_to_switch); end
        n_tests++; if (bus.write_bank_count !== 8'd1) begin n_fail++; $display("FAIL fill_done_count got=%0d exp=1", bus.write_bank_count); end
        n_tests++; if (bus.bank_sel !== 1'b0) begin n_fail++; $display("FAIL fill_done_bank_sel got=%0b exp=0", bus.bank_sel); end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 5; c++) begin
            step();
            n_tests++; if (bus.input_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_rdy_cyc%0d got=%0b exp=0", c, bus.input_rdy); end
        end
`ifdef IFMAP_STALL_CNT_EN
        n_tests++; if (stall_count !== 8'd5) begin n_fail++; $display("FAIL stall_count got=%0d exp=5", stall_count); end
`endif
        switch_bank();
        n_tests++; if (bus.bank_sel !== 1'b1) begin n_fail++; $display("FAIL switch_bank_sel got=%0b exp=1", bus.bank_sel); end
        n_tests++; if (bus.input_rdy !== 1'b1) begin n_fail++; $display("FAIL switch_rdy got=%0b exp=1", bus.input_rdy); end
        n_tests++; if (bus.write_bank_ready_to_switch !== 1'b0) begin n_fail++; $display("FAIL switch_wbrts got=%0b exp=0", bus.write_bank_ready_to_switch); end
        step();
        send(16'hBBBB);
        bus.input_vld = 1'b0;
    endtask

    task automatic test_readback();
        logic [31:0] exp;
        for (int a = 0; a < 8; a++) begin
            bus.ren   = 1'b1;
            bus.raddr = 8'(a);
            step();
            exp = {16'(2*a + 2), 16'(2*a + 1)};
            n_tests++; if (bus.rdata !== exp) begin n_fail++; $display("FAIL read_bank0_addr%0d got=%h exp=%h", a, bus.rdata, exp); end
        end
        bus.ren   = 1'b0;
        bus.raddr = 8'd3;
        step();
        step();
        n_tests++; if (bus.rdata !== 32'h0010_000F) begin n_fail++; $display("FAIL read_hold got=%h exp=0010000f", bus.rdata); end
    endtask

    task automatic test_second_bank();
        logic [31:0] exp;
        for (int k = 1; k <= 14; k++) send(16'(16'h0200 + k));
        bus.input_vld = 1'b0;
        n_tests++; if (bus.write_bank_count !== 8'd0) begin n_fail++; $display("FAIL bank1_count_wrap got=%0d exp=0", bus.write_bank_count); end
        n_tests++; if (bus.write_bank_ready_to_switch !== 1'b1) begin n_fail++; $display("FAIL bank1_wbrts got=%0b exp=1", bus.write_bank_ready_to_switch); end
        // read on the switch edge must still see bank 0
        bus.ren   = 1'b1;
        bus.raddr = 8'd2;
        switch_bank();
        n_tests++; if (bus.rdata !== 32'h0006_0005) begin n_fail++; $display("FAIL read_on_switch got=%h exp=00060005", bus.rdata); end
        n_tests++; if (bus.bank_sel !== 1'b0) begin n_fail++; $display("FAIL bank1_switch_sel got=%0b exp=0", bus.bank_sel); end
        bus.raddr = 8'd0;
        step();
        n_tests++; if (bus.rdata !== 32'hBBBB_AAAA) begin n_fail++; $display("FAIL held_beat_word got=%h exp=bbbbaaaa", bus.rdata); end
        for (int j = 1; j <= 7; j += 6) begin
            bus.raddr = 8'(j);
            step();
            exp = {16'(16'h0200 + 2*j), 16'(16'h0200 + 2*j - 1)};
            n_tests++; if (bus.rdata !== exp) begin n_fail++; $display("FAIL read_bank1_addr%0d got=%h exp=%h", j, bus.rdata, exp); end
        end
        bus.ren = 1'b0;
    endtask

    task automatic test_wrap_clamp();
        idle_inputs();
        apply_reset();
        do_config(32'd0);
        for (int b = 0; b < 512; b++) begin
            if (b == 16) begin
                n_tests++; if (bus.write_bank_ready_to_switch !== 1'b0) begin n_fail++; $display("FAIL clamp_not_full got=%0b exp=0", bus.write_bank_ready_to_switch); end
            end
            send(16'(b));
        end
        bus.input_vld = 1'b0;
        n_tests++; if (bus.write_bank_ready_to_switch !== 1'b1) begin n_fail++; $display("FAIL clamp_full got=%0b exp=1", bus.write_bank_ready_to_switch); end
        n_tests++; if (bus.write_bank_count !== 8'd1) begin n_fail++; $display("FAIL wrap_count1 got=%0d exp=1", bus.write_bank_count); end
        switch_bank();
        for (int b = 512; b < 1024; b++) send(16'(b));
        bus.input_vld = 1'b0;
        n_tests++; if (bus.write_bank_count !== 8'd0) begin n_fail++; $display("FAIL wrap_count0 got=%0d exp=0", bus.write_bank_count); end
        switch_bank();
        n_tests++; if (bus.bank_sel !== 1'b0) begin n_fail++; $display("FAIL wrap_bank_sel got=%0b exp=0", bus.bank_sel); end
        bus.ren   = 1'b1;
        bus.raddr = 8'd255;
        step();
        n_tests++; if (bus.rdata !== 32'h03FF_03FE) begin n_fail++; $display("FAIL wrap_read255 got=%h exp=03ff03fe", bus.rdata); end
        bus.raddr = 8'd0;
        step();
        n_tests++; if (bus.rdata !== 32'h0201_0200) begin n_fail++; $display("FAIL wrap_read0 got=%h exp=02010200", bus.rdata); end
        bus.ren = 1'b0;
    endtask

    task automatic test_midfill_reset();
        logic [31:0] exp;
        idle_inputs();
        apply_reset();
        do_config(32'd8);
        send(16'h1111);
        send(16'h2222);
        send(16'h3333);
        bus.input_vld = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++; if (bus.input_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rdy got=%0b exp=0", bus.input_rdy); end
        n_tests++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rst_rdata got=%h exp=0", bus.rdata); end
        n_tests++; if (bus.write_bank_count !== 8'd0) begin n_fail++; $display("FAIL mid_rst_count got=%0d exp=0", bus.write_bank_count); end
        do_config(32'd8);
        for (int k = 1; k <= 16; k++) send(16'(16'h4000 + k));
        bus.input_vld = 1'b0;
        n_tests++; if (bus.write_bank_ready_to_switch !== 1'b1) begin n_fail++; $display("FAIL mid_rst_full got=%0b exp=1", bus.write_bank_ready_to_switch); end
        switch_bank();
        for (int a = 0; a < 2; a++) begin
            bus.ren   = 1'b1;
            bus.raddr = 8'(a);
            step();
            exp = {16'(16'h4000 + 2*a + 2), 16'(16'h4000 + 2*a + 1)};
            n_tests++; if (bus.rdata !== exp) begin n_fail++; $display("FAIL mid_rst_word%0d got=%h exp=%h", a, bus.rdata, exp); end
        end
        bus.ren = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_config();
        test_fill();
        test_backpressure();
        test_readback();
        test_second_bank();
        test_wrap_clamp();
        test_midfill_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
